// File: rtl/tmr_pkg.sv
// Shared types and helpers for the TMR majority-vote stage.
package tmr_pkg;

    // Lane indices into the 3-bit per-lane vectors
    localparam int unsigned LANE_A = 0;
    localparam int unsigned LANE_B = 1;
    localparam int unsigned LANE_C = 2;

    // Per-lane health state
    typedef enum logic [1:0] {
        OK      = 2'd0,
        SUSPECT = 2'd1,
        FAULT   = 2'd2
    } lane_health_t;

    // Single-bit 2-of-3 majority; applied per bit across a word
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/tmr_lane_monitor.sv
// Per-lane health tracker: saturating mismatch counter, consecutive-mismatch
// counter and the OK/SUSPECT/FAULT state machine. FAULT is sticky until clear.
module tmr_lane_monitor
    import tmr_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FAULT_THRESH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_mismatch,
    input  logic             i_accept,
    input  logic             i_clr,
    output logic             o_fault,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [7:0] THRESH_L = 8'(FAULT_THRESH);

    lane_health_t     r_state, w_state_d;
    logic [7:0]       r_consec, w_consec_d, w_consec_inc;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;

    // Next-state: clear wins over an accepted word; stats move only on accept
    always_comb begin
        w_state_d    = r_state;
        w_consec_d   = r_consec;
        w_cnt_d      = r_cnt;
        w_consec_inc = (r_consec == 8'hFF) ? r_consec : r_consec + 8'd1;
        if (i_clr) begin
            w_state_d  = OK;
            w_consec_d = 8'd0;
            w_cnt_d    = '0;
        end else if (i_accept) begin
            if (i_mismatch) begin
                if (r_cnt != {CNT_W{1'b1}}) begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
                w_consec_d = w_consec_inc;
                unique case (r_state)
                    OK, SUSPECT: w_state_d = (w_consec_inc >= THRESH_L) ? FAULT : SUSPECT;
                    default:     w_state_d = FAULT;
                endcase
            end else begin
                w_consec_d = 8'd0;
                if (r_state == SUSPECT) begin
                    w_state_d = OK;
                end
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= OK;
            r_consec <= 8'd0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_d;
            r_consec <= w_consec_d;
            r_cnt    <= w_cnt_d;
        end
    end

    assign o_fault = (r_state == FAULT);
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/tmr_vote_stage.sv
// Registered, handshaked bitwise 2-of-3 majority voter with per-lane health
// tracking. Optional macro TMR_LANE_QUARANTINE_EN: a single faulted lane is
// excluded from the vote; with two or more faulted lanes the majority is used
// and the error flag is forced.
module tmr_vote_stage
    import tmr_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned FAULT_THRESH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_lane_a,
    input  logic [WIDTH-1:0] i_lane_b,
    input  logic [WIDTH-1:0] i_lane_c,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_err,
    output logic [2:0]       o_lane_fault,
    output logic [CNT_W-1:0] o_mism_cnt_a,
    output logic [CNT_W-1:0] o_mism_cnt_b,
    output logic [CNT_W-1:0] o_mism_cnt_c,
    input  logic             i_clr_stats
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_err;

    logic [WIDTH-1:0] w_maj, w_vote;
    logic [2:0]       w_mism;
    logic             w_err;
    logic             w_accept;
    logic [2:0]       w_fault;

    assign o_in_ready = !r_valid || i_out_ready;
    assign w_accept   = i_in_valid && o_in_ready;

    // Plain bitwise majority across the three lanes
    always_comb begin
        w_maj = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_maj[i] = maj3(i_lane_a[i], i_lane_b[i], i_lane_c[i]);
        end
    end

`ifdef TMR_LANE_QUARANTINE_EN
    logic [1:0] w_nfault;
    assign w_nfault = {1'b0, w_fault[LANE_A]} + {1'b0, w_fault[LANE_B]}
                    + {1'b0, w_fault[LANE_C]};

    // Select the produced word: lowest healthy lane when exactly one lane is faulted
    always_comb begin
        w_vote = w_maj;
        if (w_nfault == 2'd1) begin
            w_vote = w_fault[LANE_A] ? i_lane_b : i_lane_a;
        end
    end

    // Error flag: healthy pair disagreement, forced when degraded
    always_comb begin
        w_err = |w_mism;
        if (w_nfault == 2'd1) begin
            if (w_fault[LANE_A])      w_err = (i_lane_b != i_lane_c);
            else if (w_fault[LANE_B]) w_err = (i_lane_a != i_lane_c);
            else                      w_err = (i_lane_a != i_lane_b);
        end else if (w_nfault >= 2'd2) begin
            w_err = 1'b1;
        end
    end
`else
    assign w_vote = w_maj;
    assign w_err  = |w_mism;
`endif

    // Mismatch is always measured against the word actually produced
    assign w_mism[LANE_A] = (i_lane_a != w_vote);
    assign w_mism[LANE_B] = (i_lane_b != w_vote);
    assign w_mism[LANE_C] = (i_lane_c != w_vote);

    // One-entry output buffer; accept overrides drain so throughput is one word per cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= w_vote;
            r_err   <= w_err;
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    tmr_lane_monitor #(
        .CNT_W        (CNT_W),
        .FAULT_THRESH (FAULT_THRESH)
    ) u_mon_a (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_mismatch (w_mism[LANE_A]),
        .i_accept   (w_accept),
        .i_clr      (i_clr_stats),
        .o_fault    (w_fault[LANE_A]),
        .o_cnt      (o_mism_cnt_a)
    );

    tmr_lane_monitor #(
        .CNT_W        (CNT_W),
        .FAULT_THRESH (FAULT_THRESH)
    ) u_mon_b (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_mismatch (w_mism[LANE_B]),
        .i_accept   (w_accept),
        .i_clr      (i_clr_stats),
        .o_fault    (w_fault[LANE_B]),
        .o_cnt      (o_mism_cnt_b)
    );

    tmr_lane_monitor #(
        .CNT_W        (CNT_W),
        .FAULT_THRESH (FAULT_THRESH)
    ) u_mon_c (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_mismatch (w_mism[LANE_C]),
        .i_accept   (w_accept),
        .i_clr      (i_clr_stats),
        .o_fault    (w_fault[LANE_C]),
        .o_cnt      (o_mism_cnt_c)
    );

    assign o_out_valid  = r_valid;
    assign o_out_data   = r_data;
    assign o_out_err    = r_err;
    assign o_lane_fault = w_fault;

endmodule
